spi_lcd_master_gen: RTL and testbench

// - Parametrised successor to the LCD SPI master: one-word-per-request SPI master for serial LCD panels.
// - Adds configurable word width, SPI mode (CPOL/CPHA), bit order, chip-enable hold for bursts,
//   a timed power-up LCD reset pulse and a single-cycle done strobe.
// - Sits between the display controller FSM (data/command source) and the LCD pins.

---
 rtl/spi_lcd_master_gen_pkg.sv | 24 ++
 rtl/spi_lcd_master_gen_if.sv | 23 ++
 rtl/spi_lcd_master_gen_sclk_tick.sv | 36 +++
 rtl/spi_lcd_master_gen.sv | 157 +++++++++++++++
 tb/tb_spi_lcd_master_gen.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_lcd_master_gen_pkg.sv
// Shared types for the generic LCD SPI master: controller states and SPI mode encodings.
package spi_lcd_pkg;

   typedef enum logic [1:0] {
      LCD_RST = 2'd0,
      IDLE    = 2'd1,
      SHIFT   = 2'd2
   } state_t;

   // Mode encodings are {cpol, cpha}
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   function automatic logic mode_cpol(input logic [1:0] mode);
      return mode[1];
   endfunction

   function automatic logic mode_cpha(input logic [1:0] mode);
      return mode[0];
   endfunction

endpackage

// File: rtl/spi_lcd_master_gen_if.sv
// Word-level request/response bus between the display controller and the SPI master.
interface spi_lcd_master_gen_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] data_in;
   logic              cmd;
   logic              start;
   logic              keep_ce;
   logic [DATA_W-1:0] data_out;
   logic              ready;
   logic              busy;
   logic              done;

   modport master (
      output data_in, cmd, start, keep_ce,
      input  data_out, ready, busy, done
   );

   modport slave (
      input  data_in, cmd, start, keep_ce,
      output data_out, ready, busy, done
   );
endinterface

// File: rtl/spi_lcd_master_gen_sclk_tick.sv
// Half-period tick generator: one-cycle pulse every max(div,1) enabled cycles, restarted by clr.
module spi_sclk_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] period;
   logic [DIV_W-1:0] cnt;

   function automatic logic [DIV_W-1:0] sat_div(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_W'(1) : d;
   endfunction

   // Period is captured on clr so divider changes only take effect at the next word
   always_ff @(posedge clk) begin
      if (reset) begin
         period <= DIV_W'(1);
         cnt    <= '0;
      end else if (clr) begin
         period <= sat_div(div);
         cnt    <= sat_div(div) - DIV_W'(1);
      end else if (en) begin
         if (cnt == '0) cnt <= period - DIV_W'(1);
         else           cnt <= cnt - DIV_W'(1);
      end
   end

   assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_lcd_master_gen.sv
// One-word-per-request SPI master for serial LCD panels with configurable mode, width,
// bit order, burst chip-enable hold and a timed power-up LCD reset pulse.
module spi_lcd_master_gen
   import spi_lcd_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int DIV_W      = 16,
   parameter int RST_CYCLES = 1000,
   parameter int MSB_FIRST  = 1
) (
   input  logic             clk,
   input  logic             reset,
   spi_lcd_master_gen_if.slave bus,
   input  logic             cpol,
   input  logic             cpha,
   input  logic [DIV_W-1:0] div_factor,
   input  logic             miso,
   output logic             mosi,
   output logic             sclk,
   output logic             ce,
   output logic             dc,
   output logic             lcd_rst
);

   localparam int EW = $clog2(2 * DATA_W) + 1;
   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);
   localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);

   state_t            state, state_nxt;
   logic              tick, accept, rst_done, last_tick;
   logic              sample_edge, shift_edge;
   logic              ready_c, busy_c, done_r;
   logic              keep_lat, cpha_lat;
   logic [EW-1:0]     edge_cnt;
   logic [RW-1:0]     rst_cnt;
   logic [DATA_W-1:0] tx_sr, rx_sr, rx_nxt, data_out_r;

   function automatic logic head_bit(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
      return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
   endfunction

   spi_sclk_tick #(.DIV_W(DIV_W)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (accept),
      .en    (state == SHIFT),
      .div   (div_factor),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= LCD_RST;
      else       state <= state_nxt;
   end

   // Even edge_cnt means the next tick is a leading edge; odd means trailing
   always_comb begin
      state_nxt   = state;
      ready_c     = 1'b0;
      busy_c      = 1'b0;
      accept      = 1'b0;
      rst_done    = 1'b0;
      last_tick   = tick && (edge_cnt == LAST_EDGE);
      sample_edge = cpha_lat ? edge_cnt[0] : ~edge_cnt[0];
      shift_edge  = cpha_lat ? (~edge_cnt[0] && (edge_cnt != '0))
                             : (edge_cnt[0] && (edge_cnt != LAST_EDGE));
      rx_nxt      = shift_in(rx_sr, miso);
      case (state)
         LCD_RST: begin
            rst_done = (rst_cnt == RST_LAST);
            if (rst_done) state_nxt = IDLE;
         end
         IDLE: begin
            ready_c = 1'b1;
            accept  = bus.start;
            if (bus.start) state_nxt = SHIFT;
         end
         SHIFT: begin
            busy_c = 1'b1;
            if (last_tick) state_nxt = IDLE;
         end
         default: state_nxt = LCD_RST;
      endcase
   end

   // Pin-facing and handshake registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rst_cnt    <= '0;
         lcd_rst    <= 1'b0;
         mosi       <= 1'b0;
         sclk       <= cpol;
         ce         <= 1'b1;
         dc         <= 1'b0;
         data_out_r <= '0;
         done_r     <= 1'b0;
         edge_cnt   <= '0;
         keep_lat   <= 1'b0;
         cpha_lat   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            LCD_RST: begin
               sclk <= cpol;
               if (rst_done) lcd_rst <= 1'b1;
               else          rst_cnt <= rst_cnt + RW'(1);
            end
            IDLE: begin
               sclk <= cpol;
               if (accept) begin
                  ce       <= 1'b0;
                  dc       <= bus.cmd;
                  keep_lat <= bus.keep_ce;
                  cpha_lat <= cpha;
                  edge_cnt <= '0;
                  mosi     <= head_bit(bus.data_in);
               end
            end
            SHIFT: begin
               if (tick) begin
                  sclk     <= ~sclk;
                  edge_cnt <= edge_cnt + EW'(1);
                  if (shift_edge) mosi <= head_bit(tx_sr);
                  if (last_tick) begin
                     done_r     <= 1'b1;
                     data_out_r <= sample_edge ? rx_nxt : rx_sr;
                     ce         <= ~keep_lat;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Shift registers carry only data and are fully rewritten every word
   always_ff @(posedge clk) begin
      if (accept)                  tx_sr <= shift_out(bus.data_in);
      else if (tick && shift_edge) tx_sr <= shift_out(tx_sr);
      if (tick && sample_edge)     rx_sr <= rx_nxt;
   end

   assign bus.data_out = data_out_r;
   assign bus.ready    = ready_c;
   assign bus.busy     = busy_c;
   assign bus.done     = done_r;

endmodule

// File: tb/tb_spi_lcd_master_gen.sv
// Directed scoreboard bench: an 8-bit MSB-first instance and a 16-bit LSB-first instance.
module tb_spi_lcd_master_gen;
   import spi_lcd_pkg::*;

   typedef struct {
      logic [31:0] data;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel;
   logic [31:0] data_drv;
   logic        cmd_drv, start_drv, keep_drv, cpol_drv, cpha_drv;
   logic [15:0] div_drv;
   logic        loop_miso, miso_fix;

   logic mosi_a, sclk_a, ce_a, dc_a, lrst_a, miso_a;
   logic mosi_b, sclk_b, ce_b, dc_b, lrst_b, miso_b;

   logic        o_mosi, o_sclk, o_ce, o_dc, o_lrst, o_ready, o_busy, o_done;
   logic [31:0] o_dout;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   spi_lcd_master_gen_if #(.DATA_W(8))  bus_a ();
   spi_lcd_master_gen_if #(.DATA_W(16)) bus_b ();

   assign bus_a.data_in = data_drv[7:0];
   assign bus_a.cmd     = cmd_drv;
   assign bus_a.keep_ce = keep_drv;
   assign bus_a.start   = start_drv & ~sel;
   assign bus_b.data_in = data_drv[15:0];
   assign bus_b.cmd     = cmd_drv;
   assign bus_b.keep_ce = keep_drv;
   assign bus_b.start   = start_drv & sel;
   assign miso_a = loop_miso ? mosi_a : miso_fix;
   assign miso_b = loop_miso ? mosi_b : miso_fix;

   spi_lcd_master_gen #(.DATA_W(8), .DIV_W(16), .RST_CYCLES(20), .MSB_FIRST(1)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a), .cpol(cpol_drv), .cpha(cpha_drv),
      .div_factor(div_drv), .miso(miso_a), .mosi(mosi_a), .sclk(sclk_a), .ce(ce_a),
      .dc(dc_a), .lcd_rst(lrst_a)
   );

   spi_lcd_master_gen #(.DATA_W(16), .DIV_W(16), .RST_CYCLES(20), .MSB_FIRST(0)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b), .cpol(cpol_drv), .cpha(cpha_drv),
      .div_factor(div_drv), .miso(miso_b), .mosi(mosi_b), .sclk(sclk_b), .ce(ce_b),
      .dc(dc_b), .lcd_rst(lrst_b)
   );

   always_comb begin
      if (sel) begin
         o_mosi = mosi_b; o_sclk = sclk_b; o_ce = ce_b; o_dc = dc_b; o_lrst = lrst_b;
         o_ready = bus_b.ready; o_busy = bus_b.busy; o_done = bus_b.done;
         o_dout = {16'h0, bus_b.data_out};
      end else begin
         o_mosi = mosi_a; o_sclk = sclk_a; o_ce = ce_a; o_dc = dc_a; o_lrst = lrst_a;
         o_ready = bus_a.ready; o_busy = bus_a.busy; o_done = bus_a.done;
         o_dout = {24'h0, bus_a.data_out};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one word from the current negedge and follows it to its done pulse
   task automatic run_word(input logic [31:0] d, input logic c, input logic k,
                           input logic [15:0] dv, input int w, input bit msb,
                           input logic [31:0] exp_rx);
      int          eff, done_n, nrise, ce_bad;
      logic        prev_sclk, first_exp, ce_exp;
      logic [31:0] cap, mask;
      exp_t        e;
      eff    = (dv == 0) ? 1 : int'(dv);
      e.data = exp_rx;
      e.lat  = 1 + 2 * w * eff;
      sb.push_back(e);
      mask   = (32'h1 << w) - 32'h1;
      first_exp = msb ? d[w-1] : d[0];
      ce_exp = !k;
      chk("ready_before_start", {31'h0, o_ready}, 32'h1);
      data_drv = d; cmd_drv = c; keep_drv = k; div_drv = dv; start_drv = 1'b1;
      prev_sclk = o_sclk; cap = '0; nrise = 0; done_n = 0; ce_bad = 0;
      for (int n = 1; n <= e.lat + 8 && done_n == 0; n++) begin
         @(negedge clk);
         if (n == 1) begin
            start_drv = 1'b0;
            chk("ce_low_first", {31'h0, o_ce}, 32'h0);
            chk("busy_first", {31'h0, o_busy}, 32'h1);
            chk("ready_first", {31'h0, o_ready}, 32'h0);
            chk("dc_first", {31'h0, o_dc}, {31'h0, c});
            chk("mosi_first", {31'h0, o_mosi}, {31'h0, first_exp});
         end
         if (n == 3) begin
            start_drv = 1'b1; data_drv = ~d; div_drv = dv + 16'd3;
         end
         if (n == 4) start_drv = 1'b0;
         if (o_sclk && !prev_sclk) begin
            if (msb) cap = {cap[30:0], o_mosi};
            else if (nrise < 32) cap[nrise] = o_mosi;
            nrise++;
         end
         prev_sclk = o_sclk;
         if (o_done) done_n = n;
         else if (o_ce !== 1'b0) ce_bad++;
      end
      div_drv = dv;
      e = sb.pop_front();
      chk("latency", done_n, e.lat);
      chk("data_out", o_dout, e.data);
      chk("ce_held_low", ce_bad, 0);
      chk("ce_at_done", {31'h0, o_ce}, {31'h0, ce_exp});
      chk("busy_at_done", {31'h0, o_busy}, 32'h0);
      chk("ready_at_done", {31'h0, o_ready}, 32'h1);
      chk("sclk_rise_count", nrise, w);
      chk("mosi_bits", cap, d & mask);
   endtask

   task automatic idle_check();
      @(negedge clk);
      chk("done_one_cycle", {31'h0, o_done}, 32'h0);
      chk("no_queued_start", {31'h0, o_busy}, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int low, rdy_bad, edges, done_bad;
      logic prev;
      reset = 1'b1; sel = 1'b0; start_drv = 1'b0; data_drv = '0; cmd_drv = 1'b0;
      keep_drv = 1'b0; cpol_drv = 1'b0; cpha_drv = 1'b0; div_drv = 16'd2;
      loop_miso = 1'b1; miso_fix = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst_mosi", {31'h0, o_mosi}, 32'h0);
      chk("rst_sclk", {31'h0, o_sclk}, 32'h0);
      chk("rst_ce", {31'h0, o_ce}, 32'h1);
      chk("rst_dc", {31'h0, o_dc}, 32'h0);
      chk("rst_lcd_rst", {31'h0, o_lrst}, 32'h0);
      chk("rst_data_out", o_dout, 32'h0);
      chk("rst_ready", {31'h0, o_ready}, 32'h0);
      chk("rst_busy", {31'h0, o_busy}, 32'h0);
      chk("rst_done", {31'h0, o_done}, 32'h0);
      chk("rst_ce_b", {31'h0, ce_b}, 32'h1);

      // Power-up LCD reset pulse with an ignored start while it is low
      reset = 1'b0; low = 1; rdy_bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i == 4) start_drv = 1'b1;
         if (i == 5) start_drv = 1'b0;
         if (o_lrst) break;
         if (o_ready) rdy_bad++;
         low++;
      end
      chk("lcd_rst_low_cycles", low, 20);
      chk("ready_while_lcd_rst", rdy_bad, 0);
      chk("ready_after_lcd_rst", {31'h0, o_ready}, 32'h1);
      chk("start_in_lcd_rst_ignored", {31'h0, o_busy}, 32'h0);
      chk("lcd_rst_b_high", {31'h0, lrst_b}, 32'h1);

      // Mode 0, div 2, loopback
      {cpol_drv, cpha_drv} = SPI_MODE0;
      run_word(32'hA5, 1'b1, 1'b0, 16'd2, 8, 1'b1, 32'hA5);
      idle_check();

      // Mode 3, div 1, miso tied high
      cpol_drv = mode_cpol(SPI_MODE3); cpha_drv = mode_cpha(SPI_MODE3);
      loop_miso = 1'b0; miso_fix = 1'b1;
      repeat (2) @(negedge clk);
      chk("mode3_sclk_idle", {31'h0, o_sclk}, 32'h1);
      run_word(32'h3C, 1'b0, 1'b0, 16'd1, 8, 1'b1, 32'hFF);
      chk("mode3_sclk_end", {31'h0, o_sclk}, 32'h1);
      idle_check();

      // Burst of two words with ce held low
      {cpol_drv, cpha_drv} = SPI_MODE0; loop_miso = 1'b1;
      repeat (2) @(negedge clk);
      run_word(32'h12, 1'b0, 1'b1, 16'd2, 8, 1'b1, 32'h12);
      chk("burst_dc_first", {31'h0, o_dc}, 32'h0);
      run_word(32'h34, 1'b1, 1'b0, 16'd2, 8, 1'b1, 32'h34);
      idle_check();

      // Reset mid-word after five sclk edges
      data_drv = 32'h5A; cmd_drv = 1'b0; keep_drv = 1'b0; start_drv = 1'b1;
      prev = o_sclk; edges = 0;
      for (int i = 0; i < 100 && edges < 5; i++) begin
         @(negedge clk);
         start_drv = 1'b0;
         if (o_sclk != prev) edges++;
         prev = o_sclk;
      end
      chk("abort_edges_reached", edges, 5);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_ce", {31'h0, o_ce}, 32'h1);
      chk("abort_busy", {31'h0, o_busy}, 32'h0);
      chk("abort_lcd_rst", {31'h0, o_lrst}, 32'h0);
      chk("abort_done", {31'h0, o_done}, 32'h0);
      reset = 1'b0; low = 1; done_bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (o_done) done_bad++;
         if (o_lrst) break;
         low++;
      end
      chk("replay_lcd_rst_low", low, 20);
      chk("abort_no_done", done_bad, 0);

      // 16-bit LSB-first instance with div_factor 0
      sel = 1'b1; {cpol_drv, cpha_drv} = SPI_MODE0; loop_miso = 1'b1;
      repeat (2) @(negedge clk);
      run_word(32'h8001, 1'b0, 1'b0, 16'd0, 16, 1'b0, 32'h8001);
      idle_check();

      chk("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
